// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the fetch PC and chip enable to the
// combinational instruction ROM, captures the returned word into the IF/ID
// latch, and counts instructions accepted into decode.
//
// There is no valid/ready handshake here. The ROM answers in the same cycle,
// and back-pressure arrives through the stall vector:
//   stall[0] freezes the PC, stall[1] freezes IF, stall[2] freezes ID.
// IF stalled with ID running sends a bubble into decode. IF and ID both
// stalled holds the latch contents.
module if_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       fetch_cnt_o
);

    // Redirect targets are word aligned by dropping the two low bits.
    logic [ADDR_W-1:0] flush_target;
    logic [ADDR_W-1:0] branch_target;
    // An instruction is accepted into decode when IF is not stalled,
    // no flush is pending, and fetching is enabled.
    logic              accept;
    // Stall bits [5:3] belong to later stages and are not used here.
    logic              unused_stall;

    assign flush_target  = {new_pc[ADDR_W-1:2], 2'b00};
    assign branch_target = {branch_target_address_i[ADDR_W-1:2], 2'b00};
    assign accept        = !flush && !stall[1] && ce_o;
    assign unused_stall  = ^stall[5:3];

    // Chip enable: off in reset, on from the first edge after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_o <= 1'b0;
        end else begin
            ce_o <= 1'b1;
        end
    end

    // Fetch PC: priority is flush, then stall, then branch, then sequential.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o <= RESET_PC;
        end else if (!ce_o) begin
            pc_o <= RESET_PC;
        end else if (flush) begin
            pc_o <= flush_target;
        end else if (stall[0]) begin
            pc_o <= pc_o;
        end else if (branch_flag_i) begin
            pc_o <= branch_target;
        end else begin
            pc_o <= pc_o + ADDR_W'(4);
        end
    end

    // IF/ID latch: flush or an IF-only stall inserts a bubble, a running IF
    // captures the fetch, and IF plus ID stalled holds the current contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else if (flush) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else if (stall[1] && !stall[2]) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else if (!stall[1]) begin
            id_pc   <= pc_o;
            id_inst <= ce_o ? inst_i : '0;
        end else begin
            id_pc   <= id_pc;
            id_inst <= id_inst;
        end
    end

    // Fetch counter: counts every instruction accepted into the IF/ID latch.
    // It wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o <= '0;
        end else if (accept) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. A behavioural ROM returns a distinct word for
// every address. After each rising edge the bench checks every output
// against hand-derived values.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] fetch_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    if_stage #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_i                  (inst_i),
        .pc_o                    (pc_o),
        .ce_o                    (ce_o),
        .id_pc                   (id_pc),
        .id_inst                 (id_inst),
        .fetch_cnt_o             (fetch_cnt_o)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word k sits at address 4k and is tagged so it is never zero.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ (addr >> 2);
    endfunction

    assign inst_i = rom_word(pc_o);

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ce, input logic [31:0] e_pc,
                             input logic [31:0] e_idpc, input logic [31:0] e_idinst,
                             input logic [31:0] e_cnt);
        chk({tag, ".ce"},   {31'b0, ce_o}, {31'b0, e_ce});
        chk({tag, ".pc"},   pc_o,          e_pc);
        chk({tag, ".idpc"}, id_pc,         e_idpc);
        chk({tag, ".inst"}, id_inst,       e_idinst);
        chk({tag, ".cnt"},  fetch_cnt_o,   e_cnt);
    endtask

    initial begin
        rst                     = 1'b1;
        stall                   = 6'b0;
        flush                   = 1'b0;
        new_pc                  = 32'h0;
        branch_flag_i           = 1'b0;
        branch_target_address_i = 32'h0;

        // Reset held for three edges.
        step(); check_all("rst0", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); check_all("rst1", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); check_all("rst2", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        rst = 1'b0;

        // Start-up: ce rises, PC sits at 0 for one cycle, then counts up.
        step(); check_all("start1", 1'b1, 32'h0,  32'h0, 32'h0,           32'd0);
        step(); check_all("start2", 1'b1, 32'h4,  32'h0, rom_word(32'h0), 32'd1);
        step(); check_all("start3", 1'b1, 32'h8,  32'h4, rom_word(32'h4), 32'd2);
        step(); check_all("start4", 1'b1, 32'hC,  32'h8, rom_word(32'h8), 32'd3);
        step(); check_all("start5", 1'b1, 32'h10, 32'hC, rom_word(32'hC), 32'd4);

        // PC, IF and ID all stalled: everything holds.
        stall = 6'b000111;
        step(); check_all("stall_a", 1'b1, 32'h10, 32'hC, rom_word(32'hC), 32'd4);
        step(); check_all("stall_b", 1'b1, 32'h10, 32'hC, rom_word(32'hC), 32'd4);
        // IF stalled but ID free: a bubble enters decode.
        stall = 6'b000011;
        step(); check_all("bubble", 1'b1, 32'h10, 32'h0, 32'h0, 32'd4);
        stall = 6'b000000;
        step(); check_all("release", 1'b1, 32'h14, 32'h10, rom_word(32'h10), 32'd5);
        step(); check_all("run18",   1'b1, 32'h18, 32'h14, rom_word(32'h14), 32'd6);
        step(); check_all("run1c",   1'b1, 32'h1C, 32'h18, rom_word(32'h18), 32'd7);
        step(); check_all("run20",   1'b1, 32'h20, 32'h1C, rom_word(32'h1C), 32'd8);

        // Branch with a misaligned target; the delay slot at 0x20 is kept.
        branch_flag_i           = 1'b1;
        branch_target_address_i = 32'h0000_0103;
        step(); check_all("branch", 1'b1, 32'h100, 32'h20, rom_word(32'h20), 32'd9);
        branch_flag_i = 1'b0;
        step(); check_all("post_br", 1'b1, 32'h104, 32'h100, rom_word(32'h100), 32'd10);

        // Flush overrides stall and branch in the same cycle.
        stall                   = 6'b000011;
        flush                   = 1'b1;
        new_pc                  = 32'h0000_0180;
        branch_flag_i           = 1'b1;
        branch_target_address_i = 32'h0000_0200;
        step(); check_all("flush", 1'b1, 32'h180, 32'h0, 32'h0, 32'd10);
        stall         = 6'b0;
        flush         = 1'b0;
        branch_flag_i = 1'b0;
        step(); check_all("post_fl", 1'b1, 32'h184, 32'h180, rom_word(32'h180), 32'd11);

        // Flush to the top word (low bits cleared), then the PC wraps to 0.
        flush  = 1'b1;
        new_pc = 32'hFFFF_FFFF;
        step(); check_all("to_top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'd11);
        flush = 1'b0;
        step(); check_all("wrap",   1'b1, 32'h0, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 32'd12);
        step(); check_all("wrap4",  1'b1, 32'h4, 32'h0,         rom_word(32'h0),         32'd13);

        // Reset arrives in the middle of a full stall.
        stall = 6'b000111;
        step(); check_all("hold",    1'b1, 32'h4, 32'h0, rom_word(32'h0), 32'd13);
        rst = 1'b1;
        step(); check_all("mid_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        rst   = 1'b0;
        stall = 6'b0;
        // The first capture after reset has ce low, so the ROM word is gated.
        step(); check_all("restart1", 1'b1, 32'h0, 32'h0, 32'h0,           32'd0);
        step(); check_all("restart2", 1'b1, 32'h4, 32'h0, rom_word(32'h0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
